// File: rtl/data_memory_arbiter_if.sv
// Avalon-MM requester bundle used by each master port of data_memory_arbiter.
// The master modport is the requester's view; slave is the arbiter's view.
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                oob_err;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, oob_err
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, oob_err
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-master round-robin arbiter with bounded hold in front of a single-port
// data memory; 1-cycle read return, out-of-range accesses are absorbed.
module data_memory_arbiter #(
  parameter int          ADDR_W   = 15,
  parameter int          DATA_W   = 32,
  parameter int unsigned DEPTH    = 23192,
  parameter int          MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  data_memory_arbiter_if.slave m0,
  data_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  logic [1:0]      req, gnt;
  logic            gnt_any, sel;
  logic            last_g;
  logic [HC_W-1:0] hold_cnt;
  logic            wr_s, rd_s, in_range;
  logic [1:0]      rd_pend, oob_err;
  logic            rd_oob;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  // Grants are forced off during reset so waitrequest mirrors the request.
  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      if (&req) begin
        if (hold_cnt < HC_W'(MAX_HOLD)) gnt[last_g]  = 1'b1;
        else                            gnt[~last_g] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  assign gnt_any = |gnt;
  assign sel     = gnt[1];

  assign mem_address    = sel ? m1.address    : m0.address;
  assign mem_byteenable = sel ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = sel ? m1.writedata  : m0.writedata;
  assign wr_s           = sel ? m1.write : m0.write;
  // read+write together is treated as a write with no read return
  assign rd_s           = sel ? (m1.read & ~m1.write) : (m0.read & ~m0.write);
  assign in_range       = 32'(mem_address) < DEPTH;

  assign mem_chipselect = gnt_any & in_range;
  assign mem_write      = gnt_any & wr_s & in_range;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_g   <= 1'b1;
      hold_cnt <= HC_W'(MAX_HOLD);
      rd_pend  <= 2'b00;
      rd_oob   <= 1'b0;
      oob_err  <= 2'b00;
    end else begin
      rd_pend <= gnt & {2{rd_s}};
      rd_oob  <= gnt_any & rd_s & ~in_range;
      oob_err <= gnt & {2{~in_range}};
      if (gnt_any) begin
        if (sel == last_g) begin
          if (hold_cnt != HC_W'(MAX_HOLD)) hold_cnt <= hold_cnt + HC_W'(1);
        end else begin
          last_g   <= sel;
          hold_cnt <= HC_W'(1);
        end
      end
    end
  end

  assign m0.waitrequest   = req[0] & ~gnt[0];
  assign m1.waitrequest   = req[1] & ~gnt[1];
  assign m0.readdatavalid = rd_pend[0];
  assign m1.readdatavalid = rd_pend[1];
  assign m0.readdata      = rd_oob ? '0 : mem_readdata;
  assign m1.readdata      = rd_oob ? '0 : mem_readdata;
  assign m0.oob_err       = oob_err[0];
  assign m1.oob_err       = oob_err[1];
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a memory device, a history-based reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_data_memory_arbiter;
  localparam int          ADDR_W   = 15;
  localparam int          DATA_W   = 32;
  localparam int unsigned DEPTH    = 23192;
  localparam int          MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0 ();
  data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1 ();

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0), .m1(m1),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory device: registered read, byte-enabled write.
  logic [31:0] bmem [0:DEPTH-1];
  logic [31:0] smem [0:DEPTH-1];
  int bwrites = 0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) bmem[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
        bwrites = bwrites + 1;
      end else begin
        mem_readdata = bmem[mem_address];
      end
    end
  end

  // Reference model: grant from current owner's unbroken run length.
  int          owner = 1;
  int          run   = MAX_HOLD;
  bit          e_rdv [2] = '{0, 0};
  bit          e_oob [2] = '{0, 0};
  logic [31:0] e_rd  [2] = '{0, 0};

  always @(negedge clk) begin
    bit r0, r1, wr, rd, inr;
    int g;
    logic [ADDR_W-1:0] a;
    logic [3:0] be;
    logic [31:0] wd, nw;
    r0 = m0.read | m0.write;
    r1 = m1.read | m1.write;
    if (!reset_n) begin
      e_rdv = '{0, 0}; e_oob = '{0, 0};
      owner = 1; run = MAX_HOLD; g = -1;
    end else if (r0 && r1) g = (run < MAX_HOLD) ? owner : 1 - owner;
    else if (r0) g = 0;
    else if (r1) g = 1;
    else g = -1;

    chk("m0_waitrequest", 32'(m0.waitrequest), 32'(r0 && g != 0));
    chk("m1_waitrequest", 32'(m1.waitrequest), 32'(r1 && g != 1));
    chk("m0_readdatavalid", 32'(m0.readdatavalid), 32'(e_rdv[0]));
    chk("m1_readdatavalid", 32'(m1.readdatavalid), 32'(e_rdv[1]));
    chk("m0_oob_err", 32'(m0.oob_err), 32'(e_oob[0]));
    chk("m1_oob_err", 32'(m1.oob_err), 32'(e_oob[1]));
    if (e_rdv[0]) chk("m0_readdata", m0.readdata, e_rd[0]);
    if (e_rdv[1]) chk("m1_readdata", m1.readdata, e_rd[1]);
    chk("mem_clken", 32'(mem_clken), 32'd1);

    e_rdv = '{0, 0}; e_oob = '{0, 0};
    if (g < 0) begin
      chk("mem_chipselect_idle", 32'(mem_chipselect), 32'd0);
      chk("mem_write_idle", 32'(mem_write), 32'd0);
    end else begin
      a  = (g == 1) ? m1.address    : m0.address;
      be = (g == 1) ? m1.byteenable : m0.byteenable;
      wd = (g == 1) ? m1.writedata  : m0.writedata;
      wr = (g == 1) ? m1.write      : m0.write;
      rd = ((g == 1) ? m1.read : m0.read) && !wr;
      inr = (int'(a) < int'(DEPTH));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(inr));
      chk("mem_write", 32'(mem_write), 32'(wr && inr));
      if (inr) chk("mem_address", 32'(mem_address), 32'(a));
      if (wr && inr) begin
        chk("mem_byteenable", 32'(mem_byteenable), 32'(be));
        chk("mem_writedata", mem_writedata, wd);
      end
      e_oob[g] = !inr;
      if (rd) begin
        e_rdv[g] = 1;
        e_rd[g]  = inr ? smem[a] : 32'd0;
      end
      if (wr && inr) begin
        nw = smem[a];
        for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
        smem[a] = nw;
      end
      if (g == owner) run++;
      else begin owner = g; run = 1; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m0.read = 0; m0.write = 0; m1.read = 0; m1.write = 0;
  endtask

  int gs;
  int wc0;
  logic [3:0] exp_seq;
  int exp_g [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      bmem[i] = 32'(i) * 32'h9E3779B1;
      smem[i] = bmem[i];
    end
    bmem[16] = 32'hDEADBEEF; smem[16] = 32'hDEADBEEF;
    bmem[32] = 32'hAABBCCDD; smem[32] = 32'hAABBCCDD;
    m0.address = '0; m0.byteenable = '0; m0.writedata = '0;
    m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
    idle();

    // Reset: waitrequest follows the request, nothing valid.
    step();
    m0.read = 1; m0.address = 15'h0010;
    #1 chk("reset_waitrequest", 32'(m0.waitrequest), 32'd1);
    chk("reset_rdv", 32'(m0.readdatavalid), 32'd0);
    step();
    reset_n = 1;

    // Single read, 1-cycle return.
    #1 chk("rd_accept", 32'(m0.waitrequest), 32'd0);
    step(); idle();
    #1 chk("rd_valid", 32'(m0.readdatavalid), 32'd1);
    chk("rd_data", m0.readdata, 32'hDEADBEEF);

    // Byte-enabled write then read back.
    m0.write = 1; m0.address = 15'h0020; m0.writedata = 32'h11223344; m0.byteenable = 4'b0101;
    #1 chk("wr_mem_write", 32'(mem_write), 32'd1);
    chk("wr_byteenable", 32'(mem_byteenable), 32'h5);
    step(); idle(); m0.read = 1;
    step(); idle();
    #1 chk("wr_readback", m0.readdata, 32'hAA22CC44);

    // Contention after a fresh reset: m0 x4, m1 x4, m0.
    step(); reset_n = 0;
    step(); reset_n = 1;
    step();
    m0.read = 1; m0.address = 15'h0100;
    m1.read = 1; m1.address = 15'h0200;
    for (int i = 0; i < 9; i++) begin
      #1;
      exp_seq = {m1.waitrequest, m0.waitrequest, 2'b00};
      gs = !m0.waitrequest ? 0 : (!m1.waitrequest ? 1 : 2);
      chk($sformatf("grant_seq[%0d]", i), 32'(gs), 32'(exp_g[i]));
      step();
    end
    idle();
    step();

    // Out-of-range read and write from m1.
    m1.read = 1; m1.address = 15'h5A98;
    #1 chk("oob_rd_accept", 32'(m1.waitrequest), 32'd0);
    chk("oob_rd_cs", 32'(mem_chipselect), 32'd0);
    step(); idle();
    #1 chk("oob_rd_valid", 32'(m1.readdatavalid), 32'd1);
    chk("oob_rd_data", m1.readdata, 32'd0);
    chk("oob_rd_err", 32'(m1.oob_err), 32'd1);
    wc0 = bwrites;
    m1.write = 1; m1.address = 15'h7FFF; m1.writedata = 32'hCAFEF00D; m1.byteenable = 4'hF;
    #1 chk("oob_wr_mem_write", 32'(mem_write), 32'd0);
    step(); idle();
    #1 chk("oob_wr_err", 32'(m1.oob_err), 32'd1);
    chk("oob_wr_no_mem", 32'(bwrites), 32'(wc0));
    step();

    // Read and write together: write wins, no read return.
    m0.read = 1; m0.write = 1; m0.address = 15'h0030; m0.writedata = 32'h55667788; m0.byteenable = 4'hF;
    #1 chk("rw_mem_write", 32'(mem_write), 32'd1);
    step(); idle();
    #1 chk("rw_no_rdv", 32'(m0.readdatavalid), 32'd0);
    m0.read = 1;
    step(); idle();
    #1 chk("rw_readback", m0.readdata, 32'h55667788);
    step();

    // Reset lands while a read return is pending.
    m0.read = 1; m0.address = 15'h0040;
    #1 chk("rst_rd_accept", 32'(m0.waitrequest), 32'd0);
    step(); idle(); reset_n = 0;
    #1 chk("rst_rdv_during", 32'(m0.readdatavalid), 32'd0);
    step(); step(); reset_n = 1;
    #1 chk("rst_rdv_after", 32'(m0.readdatavalid), 32'd0);
    step();
    m0.read = 1; m1.read = 1;
    #1 chk("rst_m0_wins", 32'(m0.waitrequest), 32'd0);
    chk("rst_m1_waits", 32'(m1.waitrequest), 32'd1);
    step(); idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port on-chip data memory (32-bit words, 15-bit word address, byte enables, 23192 words) between two Avalon-MM requesters, m0 and m1.
- Issues at most one access per cycle to the memory port.
- Arbitration is round-robin with a bounded hold, so a streaming master cannot starve the other.
- Returns read data with fixed 1-cycle latency, and blocks out-of-range addresses from reaching the memory.

Parameters:
ADDR_W, 15, word address width
DATA_W, 32, data width (byteenable width = DATA_W/8)
DEPTH, 23192, number of valid words; addresses >= DEPTH are out of range
MAX_HOLD, 4, max consecutive grants to one master while the other is requesting (>=1)

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous reset, active-low
m0_address  in  ADDR_W  word address
m0_byteenable  in  DATA_W/8  byte enables for writes
m0_read  in  1  read request
m0_write  in  1  write request
m0_writedata  in  DATA_W  write data
m0_waitrequest  out  1  request not accepted this cycle
m0_readdata  out  DATA_W  read data
m0_readdatavalid  out  1  m0_readdata valid this cycle
m0_oob_err  out  1  1-cycle pulse: out-of-range access accepted
m1_*  same set as m0_*, for requester 1
mem_address  out  ADDR_W  to memory
mem_byteenable  out  DATA_W/8  to memory
mem_chipselect  out  1  to memory
mem_write  out  1  to memory
mem_writedata  out  DATA_W  to memory
mem_clken  out  1  constant 1
mem_readdata  in  DATA_W  memory output; valid 1 cycle after the address is issued

Behaviour:
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, the access is a write and produces no readdatavalid.
- Grant is combinational from the current requests and registered arbitration state. Exactly one or zero grants per cycle.
- waitrequest: mN_waitrequest = reqN & ~grantN. A master holds its request stable until waitrequest is low.
- Arbitration state: last_g (1 bit), hold_cnt (0..MAX_HOLD).
  - Reset values: last_g=1, hold_cnt=MAX_HOLD, so m0 wins the first contention.
- Arbitration rules:
  - Only one requester: it is granted.
  - Both request and hold_cnt < MAX_HOLD: grant last_g.
  - Both request and hold_cnt == MAX_HOLD: grant ~last_g.
  - No request: no grant, state unchanged.
- On any grant:
  - Granted master == last_g: hold_cnt saturating-increments.
  - Otherwise: last_g <= granted master, hold_cnt <= 1.
- Memory mux:
  - mem_address, mem_byteenable and mem_writedata follow the granted master.
  - With no grant, they follow m0 and mem_chipselect=0.
  - mem_write = grant & write_granted & in_range.
  - mem_chipselect = grant & in_range.
- Range check: in_range = (address < DEPTH), unsigned compare on ADDR_W bits.
  - Out-of-range access is still accepted (waitrequest low) but never drives the memory.
  - mN_oob_err pulses for 1 cycle, registered, in the cycle after acceptance.
- Read return: registered rd_pend[1:0] and rd_oob, set in the cycle a read is granted.
  - Next cycle: mN_readdatavalid=1.
  - mN_readdata = rd_oob ? 0 : mem_readdata (combinational pass-through).
  - With no readdatavalid, readdata is don't-care.
- Throughput: 1 access/cycle. Back-to-back reads from either or alternating masters are fully pipelined.
- Reset values: all readdatavalid=0, oob_err=0, rd_pend=0, rd_oob=0. waitrequest = reqN during reset, because all grants are forced to 0 while reset_n is low.
- Reset asserted mid-operation clears a pending readdatavalid; no late return follows reset release.
- mem_clken tied to 1.

Test Plan:
- Reset, then m0 read addr 0x0010 (mem holds 0xDEADBEEF) -> m0_waitrequest=0 same cycle; next cycle m0_readdatavalid=1, m0_readdata=0xDEADBEEF.
- m0 write 0x0020 data 0x11223344 byteenable 0b0101, then read -> mem_write=1, mem_byteenable=0b0101; read returns only bytes 0 and 2 updated.
- Both masters read continuously, MAX_HOLD=4 -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0...; waitrequest high on the loser; readdatavalid on the correct master each following cycle.
- m1 read addr 23192 (0x5A98) -> accepted, mem_chipselect=0, next cycle m1_readdatavalid=1, m1_readdata=0, m1_oob_err=1; m1 write 0x7FFF -> mem_write=0, m1_oob_err pulse, memory unchanged.
- m0 asserts read and write together at 0x0030 -> write performed, no m0_readdatavalid.
- m0 read granted, reset_n low the next cycle -> m0_readdatavalid=0 during and after reset; after release, m0 wins first contention.
